data_mem_access_unit: RTL and testbench

- Load/store execution unit for the datapath. Consumes the decoder's memory controls (MemRead, MemWrite, size_in, load_sign) plus the ALU-computed address and the rt store data.
- Performs byte/half/word accesses over a word-wide, req/ack data-memory bus.
- Stalls the pipeline while a bus transaction is outstanding. Returns a sign- or zero-extended load value for writeback.

---
 rtl/data_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// Load/store unit: byte/half/word accesses over a req/ack word bus.
// Stalls the pipeline while a transaction is outstanding.
module data_mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size_in,
  input  logic              load_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rd_q, rd_d;
  logic              done_q, done_d;
  logic              berr_q, berr_d;
  logic              aerr_q, aerr_d;

  logic              req_in;
  logic              bad_req;
  logic              sz_b, sz_h, sz_w;
  logic [3:0]        be_new;
  logic [31:0]       wd_new;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;

  assign req_in = mem_read | mem_write;
  assign sz_b   = (size_in == 2'b00);
  assign sz_h   = (size_in == 2'b01);
  assign sz_w   = (size_in == 2'b11);

  // Flag conflicting, illegal-size or misaligned requests.
  always_comb begin
    bad_req = 1'b0;
    if (mem_read && mem_write) begin
      bad_req = 1'b1;
    end
    unique case (1'b1)
      sz_b:    bad_req = bad_req;
      sz_h:    if (addr[0]) bad_req = 1'b1;
      sz_w:    if (addr[1:0] != 2'b00) bad_req = 1'b1;
      default: bad_req = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be_new = 4'b0000;
    wd_new = 32'h0;
    unique case (1'b1)
      sz_b: begin
        be_new = 4'b0001 << addr[1:0];
        wd_new = {4{wr_data[7:0]}};
      end
      sz_h: begin
        be_new = addr[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{wr_data[15:0]}};
      end
      sz_w: begin
        be_new = 4'b1111;
        wd_new = wr_data;
      end
      default: begin
        be_new = 4'b0000;
        wd_new = 32'h0;
      end
    endcase
  end

  // Extract the addressed lane and extend it.
  always_comb begin
    ld_byte = bus_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? bus_rdata[31:16]
                        : bus_rdata[15:0];
    ld_val  = bus_rdata;
    unique case (size_q)
      2'b00:
        ld_val = {{24{sign_q & ld_byte[7]}},
                  ld_byte};
      2'b01:
        ld_val = {{16{sign_q & ld_half[15]}},
                  ld_half};
      default:
        ld_val = bus_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    lane_d  = lane_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    berr_d  = 1'b0;
    aerr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          if (bad_req) begin
            aerr_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = be_new;
            wdata_d = wd_new;
            size_d  = size_in;
            sign_d  = load_sign;
            lane_d  = addr[1:0];
            cnt_d   = 8'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rd_d = ld_val;
          end
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          rd_d    = 32'h0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and bus registers; reset drops the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      lane_q  <= 2'b00;
      rd_q    <= 32'h0;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      berr_q  <= berr_d;
      aerr_q  <= aerr_d;
    end
  end

  // Stall covers the accepting cycle and all of BUSY.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      stall = (state_q == BUSY) ||
              ((state_q == IDLE) && req_in && !bad_req);
    end
  end

  assign rd_data   = rd_q;
  assign done      = done_q;
  assign bus_err   = berr_q;
  assign addr_err  = aerr_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit.
// Vector table plus timeout and reset sequences.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        load_sign = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] rd_data;
  logic        done, stall, addr_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_access_unit #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .size_in(size_in), .load_sign(load_sign),
    .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .done(done),
    .stall(stall), .addr_err(addr_err),
    .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          dly;
    logic        err;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[15];

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    size_in   = v.sz;
    load_sign = v.sg;
    addr      = v.a;
    wr_data   = v.wd;
    #1;
    chk({s, " stall_accept"}, 32'(stall),
        32'(!v.err));
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (v.err) begin
      chk({s, " addr_err"}, 32'(addr_err), 32'd1);
      chk({s, " no_req"}, 32'(bus_req), 32'd0);
      chk({s, " stall0"}, 32'(stall), 32'd0);
      @(negedge clk);
      chk({s, " addr_err_pulse"},
          32'(addr_err), 32'd0);
      chk({s, " rd_hold"}, rd_data, v.exp_rd);
    end else begin
      for (int k = 1; k <= v.dly; k++) begin
        chk({s, " req"}, 32'(bus_req), 32'd1);
        chk({s, " we"}, 32'(bus_we), 32'(v.wr));
        chk({s, " baddr"}, bus_addr,
            {v.a[31:2], 2'b00});
        chk({s, " be"}, 32'(bus_be), 32'(v.be));
        chk({s, " wdata"}, bus_wdata, v.exp_wd);
        chk({s, " stall_busy"}, 32'(stall), 32'd1);
        chk({s, " no_done"}, 32'(done), 32'd0);
        if (k == v.dly) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdat;
        end
        @(negedge clk);
      end
      bus_ack = 1'b0;
      chk({s, " done"}, 32'(done), 32'd1);
      chk({s, " bus_err"}, 32'(bus_err), 32'd0);
      chk({s, " req_drop"}, 32'(bus_req), 32'd0);
      chk({s, " stall_done"}, 32'(stall), 32'd0);
      chk({s, " rd_data"}, rd_data, v.exp_rd);
      @(negedge clk);
      chk({s, " done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  task automatic start_lw(input logic [31:0] a);
    @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    size_in   = 2'b11;
    load_sign = 1'b0;
    addr      = a;
    @(negedge clk);
    mem_read  = 1'b0;
  endtask

  initial begin
    vt[0]  = '{0,1,2'b11,0,32'h104,32'hDEADBEEF,0,
               2,0,4'hF,32'hDEADBEEF,32'h0};
    vt[1]  = '{1,0,2'b00,1,32'h203,0,32'h80123456,
               1,0,4'h8,0,32'hFFFFFF80};
    vt[2]  = '{1,0,2'b00,0,32'h203,0,32'h80123456,
               3,0,4'h8,0,32'h00000080};
    vt[3]  = '{1,0,2'b01,1,32'h202,0,32'h9ABC1234,
               2,0,4'hC,0,32'hFFFF9ABC};
    vt[4]  = '{1,0,2'b01,1,32'h201,0,0,
               0,1,4'h0,0,32'hFFFF9ABC};
    vt[5]  = '{0,1,2'b00,0,32'h11,32'hA5,0,
               1,0,4'h2,32'hA5A5A5A5,32'hFFFF9ABC};
    vt[6]  = '{0,1,2'b01,0,32'h12,32'hBEEF,0,
               1,0,4'hC,32'hBEEFBEEF,32'hFFFF9ABC};
    vt[7]  = '{1,0,2'b01,0,32'h200,0,32'h9ABC8234,
               1,0,4'h3,0,32'h00008234};
    vt[8]  = '{1,0,2'b00,1,32'h200,0,32'h1122337F,
               1,0,4'h1,0,32'h0000007F};
    vt[9]  = '{1,0,2'b11,1,32'h300,0,32'h80000001,
               4,0,4'hF,0,32'h80000001};
    vt[10] = '{1,0,2'b00,1,32'h201,0,32'h0000C300,
               1,0,4'h2,0,32'hFFFFFFC3};
    vt[11] = '{1,0,2'b10,0,32'h300,0,0,
               0,1,4'h0,0,32'hFFFFFFC3};
    vt[12] = '{1,1,2'b11,0,32'h300,0,0,
               0,1,4'h0,0,32'hFFFFFFC3};
    vt[13] = '{1,0,2'b11,0,32'h302,0,0,
               0,1,4'h0,0,32'hFFFFFFC3};
    vt[14] = '{0,1,2'b01,0,32'h203,32'h1234,0,
               0,1,4'h0,0,32'hFFFFFFC3};

    #3;
    chk("rst rd_data", rd_data, 32'h0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst addr_err", 32'(addr_err), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vt[i], i);
    end

    // ack while idle is ignored
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("idle_ack req", 32'(bus_req), 32'd0);
    chk("idle_ack done", 32'(done), 32'd0);

    // timeout: no ack for 16 BUSY cycles
    start_lw(32'h400);
    for (int k = 1; k <= 16; k++) begin
      chk("to req", 32'(bus_req), 32'd1);
      chk("to no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("to done", 32'(done), 32'd1);
    chk("to bus_err", 32'(bus_err), 32'd1);
    chk("to req_drop", 32'(bus_req), 32'd0);
    chk("to rd_zero", rd_data, 32'h0);
    chk("to stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("to done_pulse", 32'(done), 32'd0);
    chk("to berr_pulse", 32'(bus_err), 32'd0);

    // ack in the 16th BUSY cycle wins
    start_lw(32'h404);
    for (int k = 1; k <= 16; k++) begin
      chk("ack16 req", 32'(bus_req), 32'd1);
      if (k == 16) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    chk("ack16 done", 32'(done), 32'd1);
    chk("ack16 bus_err", 32'(bus_err), 32'd0);
    chk("ack16 rd", rd_data, 32'h12345678);

    // reset during BUSY
    start_lw(32'h500);
    chk("rstb req", 32'(bus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstb req_drop", 32'(bus_req), 32'd0);
    chk("rstb stall", 32'(stall), 32'd0);
    chk("rstb done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstb no_done", 32'(done), 32'd0);
      chk("rstb no_req", 32'(bus_req), 32'd0);
    end
    run_vec('{1,0,2'b11,0,32'h500,0,32'hCAFEF00D,
              1,0,4'hF,0,32'hCAFEF00D}, 99);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
